// File: rtl/exu_oitf_pkg.sv
// Shared widths, pointer type and pointer-advance helper for the
// outstanding instruction track FIFO.
package exu_oitf_pkg;

    localparam int OITF_DEPTH_DFLT = 4;
    localparam int ITAG_WIDTH      = 2;
    localparam int RFIDX_WIDTH     = 5;
    localparam int PC_SIZE         = 32;

    typedef struct packed {
        logic                  flg;
        logic [ITAG_WIDTH-1:0] idx;
    } oitf_ptr_t;

    // The flag bit flips on every wrap so equal indices can be told apart as full or empty.
    function automatic oitf_ptr_t ptr_adv(input oitf_ptr_t p, input int depth);
        oitf_ptr_t n;
        if (p.idx == ITAG_WIDTH'(depth - 1)) begin
            n.idx = '0;
            n.flg = ~p.flg;
        end else begin
            n.idx = p.idx + 1'b1;
            n.flg = p.flg;
        end
        return n;
    endfunction

endpackage

// File: rtl/exu_oitf.sv
// Outstanding instruction track FIFO: allocates itags for long-pipe
// instructions at dispatch, flags RAW/WAW hazards, retires entries in order.
module exu_oitf
    import exu_oitf_pkg::*;
#(
    parameter int OITF_DEPTH = OITF_DEPTH_DFLT
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   disp_oitf_ena,
    output logic                   disp_oitf_ready,
    output logic [ITAG_WIDTH-1:0]  disp_oitf_ptr,
    input  logic                   disp_oitf_rs1en,
    input  logic                   disp_oitf_rs2en,
    input  logic                   disp_oitf_rdwen,
    input  logic [RFIDX_WIDTH-1:0] disp_oitf_rs1idx,
    input  logic [RFIDX_WIDTH-1:0] disp_oitf_rs2idx,
    input  logic [RFIDX_WIDTH-1:0] disp_oitf_rdidx,
    input  logic [PC_SIZE-1:0]     disp_oitf_pc,

    output logic                   oitfrd_match_disprs1,
    output logic                   oitfrd_match_disprs2,
    output logic                   oitfrd_match_disprd,
    output logic                   oitf_empty,

    input  logic                   oitf_ret_ena,
    output logic [ITAG_WIDTH-1:0]  oitf_ret_ptr,
    output logic                   oitf_ret_rdwen,
    output logic [RFIDX_WIDTH-1:0] oitf_ret_rdidx,
    output logic [PC_SIZE-1:0]     oitf_ret_pc
);

    logic                   ent_vld   [OITF_DEPTH];
    logic                   ent_rdwen [OITF_DEPTH];
    logic [RFIDX_WIDTH-1:0] ent_rdidx [OITF_DEPTH];
    logic [PC_SIZE-1:0]     ent_pc    [OITF_DEPTH];

    oitf_ptr_t alc_ptr;
    oitf_ptr_t ret_ptr;

    logic same_idx;
    logic full;
    logic empty;
    logic alc_fire;
    logic ret_fire;

    assign same_idx = (alc_ptr.idx == ret_ptr.idx);
    assign empty    = same_idx & (alc_ptr.flg == ret_ptr.flg);
    assign full     = same_idx & (alc_ptr.flg != ret_ptr.flg);

    // When full or empty only one side may move, so alloc and retire never hit the same slot.
    assign alc_fire = disp_oitf_ena & ~full;
    assign ret_fire = oitf_ret_ena & ~empty;

    assign disp_oitf_ready = ~full;
    assign oitf_empty      = empty;
    assign disp_oitf_ptr   = alc_ptr.idx;
    assign oitf_ret_ptr    = ret_ptr.idx;

    assign oitf_ret_rdwen  = ent_rdwen[ret_ptr.idx];
    assign oitf_ret_rdidx  = ent_rdidx[ret_ptr.idx];
    assign oitf_ret_pc     = ent_pc[ret_ptr.idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alc_ptr <= '0;
            ret_ptr <= '0;
        end else begin
            if (alc_fire) begin
                alc_ptr <= ptr_adv(alc_ptr, OITF_DEPTH);
            end
            if (ret_fire) begin
                ret_ptr <= ptr_adv(ret_ptr, OITF_DEPTH);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OITF_DEPTH; i++) begin
                ent_vld[i]   <= 1'b0;
                ent_rdwen[i] <= 1'b0;
                ent_rdidx[i] <= '0;
                ent_pc[i]    <= '0;
            end
        end else begin
            if (alc_fire) begin
                ent_vld[alc_ptr.idx]   <= 1'b1;
                ent_rdwen[alc_ptr.idx] <= disp_oitf_rdwen;
                ent_rdidx[alc_ptr.idx] <= disp_oitf_rdidx;
                ent_pc[alc_ptr.idx]    <= disp_oitf_pc;
            end
            if (ret_fire) begin
                ent_vld[ret_ptr.idx] <= 1'b0;
            end
        end
    end

    logic [OITF_DEPTH-1:0] hit_rs1;
    logic [OITF_DEPTH-1:0] hit_rs2;
    logic [OITF_DEPTH-1:0] hit_rd;

    // Retiring entries still hit this cycle; new allocations appear next cycle.
    for (genvar g = 0; g < OITF_DEPTH; g++) begin : g_match
        logic wr_live;
        assign wr_live    = ent_vld[g] & ent_rdwen[g];
        assign hit_rs1[g] = wr_live & (ent_rdidx[g] == disp_oitf_rs1idx);
        assign hit_rs2[g] = wr_live & (ent_rdidx[g] == disp_oitf_rs2idx);
        assign hit_rd[g]  = wr_live & (ent_rdidx[g] == disp_oitf_rdidx);
    end

    assign oitfrd_match_disprs1 = (|hit_rs1) & disp_oitf_rs1en & (disp_oitf_rs1idx != '0);
    assign oitfrd_match_disprs2 = (|hit_rs2) & disp_oitf_rs2en & (disp_oitf_rs2idx != '0);
    assign oitfrd_match_disprd  = (|hit_rd)  & disp_oitf_rdwen & (disp_oitf_rdidx  != '0);

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(disp_oitf_ena && full))
                else $warning("exu_oitf: allocate while full ignored");
            assert (!(oitf_ret_ena && empty))
                else $warning("exu_oitf: retire while empty ignored");
        end
    end
`endif

endmodule

// File: tb/tb_exu_oitf.sv
// Directed bench for exu_oitf: fill/full, hazard matching, simultaneous
// alloc/retire corners, pointer wrap and asynchronous reset.
module tb_exu_oitf;
    import exu_oitf_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   disp_oitf_ena;
    logic                   disp_oitf_ready;
    logic [ITAG_WIDTH-1:0]  disp_oitf_ptr;
    logic                   disp_oitf_rs1en;
    logic                   disp_oitf_rs2en;
    logic                   disp_oitf_rdwen;
    logic [RFIDX_WIDTH-1:0] disp_oitf_rs1idx;
    logic [RFIDX_WIDTH-1:0] disp_oitf_rs2idx;
    logic [RFIDX_WIDTH-1:0] disp_oitf_rdidx;
    logic [PC_SIZE-1:0]     disp_oitf_pc;
    logic                   oitfrd_match_disprs1;
    logic                   oitfrd_match_disprs2;
    logic                   oitfrd_match_disprd;
    logic                   oitf_empty;
    logic                   oitf_ret_ena;
    logic [ITAG_WIDTH-1:0]  oitf_ret_ptr;
    logic                   oitf_ret_rdwen;
    logic [RFIDX_WIDTH-1:0] oitf_ret_rdidx;
    logic [PC_SIZE-1:0]     oitf_ret_pc;

    int checks = 0;
    int errors = 0;

    exu_oitf dut (
        .clk                  (clk),
        .rst                  (rst),
        .disp_oitf_ena        (disp_oitf_ena),
        .disp_oitf_ready      (disp_oitf_ready),
        .disp_oitf_ptr        (disp_oitf_ptr),
        .disp_oitf_rs1en      (disp_oitf_rs1en),
        .disp_oitf_rs2en      (disp_oitf_rs2en),
        .disp_oitf_rdwen      (disp_oitf_rdwen),
        .disp_oitf_rs1idx     (disp_oitf_rs1idx),
        .disp_oitf_rs2idx     (disp_oitf_rs2idx),
        .disp_oitf_rdidx      (disp_oitf_rdidx),
        .disp_oitf_pc         (disp_oitf_pc),
        .oitfrd_match_disprs1 (oitfrd_match_disprs1),
        .oitfrd_match_disprs2 (oitfrd_match_disprs2),
        .oitfrd_match_disprd  (oitfrd_match_disprd),
        .oitf_empty           (oitf_empty),
        .oitf_ret_ena         (oitf_ret_ena),
        .oitf_ret_ptr         (oitf_ret_ptr),
        .oitf_ret_rdwen       (oitf_ret_rdwen),
        .oitf_ret_rdidx       (oitf_ret_rdidx),
        .oitf_ret_pc          (oitf_ret_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alloc(input logic ena, input int rd, input logic wen, input int pc);
        disp_oitf_ena   = ena;
        disp_oitf_rdidx = RFIDX_WIDTH'(rd);
        disp_oitf_rdwen = wen;
        disp_oitf_pc    = PC_SIZE'(pc);
    endtask

    task automatic set_haz(input logic e1, input int r1, input logic e2, input int r2,
                           input logic ew, input int rw);
        disp_oitf_rs1en  = e1;
        disp_oitf_rs1idx = RFIDX_WIDTH'(r1);
        disp_oitf_rs2en  = e2;
        disp_oitf_rs2idx = RFIDX_WIDTH'(r2);
        disp_oitf_rdwen  = ew;
        disp_oitf_rdidx  = RFIDX_WIDTH'(rw);
    endtask

    initial begin
        rst           = 1'b0;
        oitf_ret_ena  = 1'b0;
        set_alloc(1'b0, 0, 1'b0, 0);
        set_haz(1'b0, 0, 1'b0, 0, 1'b0, 0);

        #1 rst = 1'b1;
        set_haz(1'b1, 1, 1'b1, 2, 1'b1, 3);
        #1;
        check("rst_ready",   disp_oitf_ready, 1);
        check("rst_empty",   oitf_empty, 1);
        check("rst_ptr",     disp_oitf_ptr, 0);
        check("rst_ret_ptr", oitf_ret_ptr, 0);
        check("rst_m_rs1",   oitfrd_match_disprs1, 0);
        check("rst_m_rd",    oitfrd_match_disprd, 0);
        set_haz(1'b0, 0, 1'b0, 0, 1'b0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Fill: itags 0..3, ready drops after the fourth
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("fill_ptr_pre%0d", i), disp_oitf_ptr, i - 1);
            set_alloc(1'b1, i, 1'b1, 'h100 + 4 * i);
            tick();
            check($sformatf("fill_ready%0d", i), disp_oitf_ready, (i < 4) ? 1 : 0);
            check($sformatf("fill_empty%0d", i), oitf_empty, 0);
        end

        set_alloc(1'b1, 6, 1'b1, 'h900);
        tick();
        set_alloc(1'b0, 0, 1'b0, 0);
        check("full_ena_ptr",     disp_oitf_ptr, 0);
        check("full_ena_ready",   disp_oitf_ready, 0);
        check("full_ena_retptr",  oitf_ret_ptr, 0);
        check("full_ena_retrd",   oitf_ret_rdidx, 1);
        check("full_ena_retpc",   oitf_ret_pc, 'h104);
        check("full_ena_retwen",  oitf_ret_rdwen, 1);

        // Full with both enables: only the retire happens
        set_alloc(1'b1, 8, 1'b1, 'h800);
        oitf_ret_ena = 1'b1;
        tick();
        set_alloc(1'b0, 0, 1'b0, 0);
        oitf_ret_ena = 1'b0;
        check("full_both_retptr", oitf_ret_ptr, 1);
        check("full_both_ready",  disp_oitf_ready, 1);
        check("full_both_ptr",    disp_oitf_ptr, 0);
        check("full_both_retrd",  oitf_ret_rdidx, 2);

        oitf_ret_ena = 1'b1;
        repeat (3) tick();
        oitf_ret_ena = 1'b0;
        check("drain1_empty",  oitf_empty, 1);
        check("drain1_retptr", oitf_ret_ptr, 0);
        check("drain1_ready",  disp_oitf_ready, 1);

        // Empty with both enables: only the allocate happens
        set_alloc(1'b1, 5, 1'b1, 'h200);
        oitf_ret_ena = 1'b1;
        tick();
        oitf_ret_ena = 1'b0;
        check("empty_both_empty",  oitf_empty, 0);
        check("empty_both_retptr", oitf_ret_ptr, 0);
        check("empty_both_ptr",    disp_oitf_ptr, 1);
        check("empty_both_retrd",  oitf_ret_rdidx, 5);
        check("empty_both_retpc",  oitf_ret_pc, 'h200);

        set_alloc(1'b1, 7, 1'b1, 'h204);
        tick();
        set_alloc(1'b1, 0, 1'b1, 'h208);
        tick();
        set_alloc(1'b0, 0, 1'b0, 0);
        check("haz_setup_ptr", disp_oitf_ptr, 3);

        // In flight: rd 5, 7, 0
        set_haz(1'b1, 5, 1'b0, 7, 1'b1, 7);
        #1;
        check("haz_a_rs1", oitfrd_match_disprs1, 1);
        check("haz_a_rs2", oitfrd_match_disprs2, 0);
        check("haz_a_rd",  oitfrd_match_disprd, 1);
        set_haz(1'b1, 3, 1'b1, 7, 1'b0, 7);
        #1;
        check("haz_b_rs1", oitfrd_match_disprs1, 0);
        check("haz_b_rs2", oitfrd_match_disprs2, 1);
        check("haz_b_rd",  oitfrd_match_disprd, 0);
        set_haz(1'b1, 0, 1'b1, 0, 1'b1, 0);
        #1;
        check("haz_x0_rs1", oitfrd_match_disprs1, 0);
        check("haz_x0_rs2", oitfrd_match_disprs2, 0);
        check("haz_x0_rd",  oitfrd_match_disprd, 0);

        // Allocation becomes visible only on the following cycle
        set_haz(1'b1, 9, 1'b0, 0, 1'b1, 9);
        disp_oitf_ena = 1'b1;
        disp_oitf_pc  = 'h20c;
        #1;
        check("vis_pre_rs1", oitfrd_match_disprs1, 0);
        check("vis_pre_rd",  oitfrd_match_disprd, 0);
        tick();
        disp_oitf_ena = 1'b0;
        check("vis_post_rs1",  oitfrd_match_disprs1, 1);
        check("vis_post_rd",   oitfrd_match_disprd, 1);
        check("vis_post_full", disp_oitf_ready, 0);

        // Retiring entry still matches in its retire cycle
        set_haz(1'b1, 5, 1'b0, 0, 1'b0, 0);
        oitf_ret_ena = 1'b1;
        #1;
        check("ret_pre_rs1", oitfrd_match_disprs1, 1);
        tick();
        oitf_ret_ena = 1'b0;
        check("ret_post_rs1",   oitfrd_match_disprs1, 0);
        check("ret_post_retptr", oitf_ret_ptr, 1);
        check("ret_post_retrd",  oitf_ret_rdidx, 7);

        set_haz(1'b0, 0, 1'b0, 0, 1'b0, 0);
        oitf_ret_ena = 1'b1;
        repeat (3) tick();
        oitf_ret_ena = 1'b0;
        check("drain2_empty",  oitf_empty, 1);
        check("drain2_ptr",    disp_oitf_ptr, 0);
        check("drain2_retptr", oitf_ret_ptr, 0);

        // Steady state: one entry in flight, 10 alloc+retire cycles, two wraps each side
        set_alloc(1'b1, 10, 1'b1, 'h300);
        tick();
        for (int k = 0; k < 10; k++) begin
            set_alloc(1'b1, 11 + k, 1'b1, 'h304 + 4 * k);
            oitf_ret_ena = 1'b1;
            tick();
            check($sformatf("ss_ptr%0d", k),    disp_oitf_ptr, (k + 2) % 4);
            check($sformatf("ss_retptr%0d", k), oitf_ret_ptr, (k + 1) % 4);
            check($sformatf("ss_ready%0d", k),  disp_oitf_ready, 1);
            check($sformatf("ss_empty%0d", k),  oitf_empty, 0);
            check($sformatf("ss_retrd%0d", k),  oitf_ret_rdidx, 11 + k);
        end
        set_alloc(1'b0, 0, 1'b0, 0);
        tick();
        oitf_ret_ena = 1'b0;
        check("ss_end_empty",  oitf_empty, 1);
        check("ss_end_retptr", oitf_ret_ptr, 3);

        // Asynchronous reset with three entries in flight
        for (int j = 0; j < 3; j++) begin
            set_alloc(1'b1, 12 + j, 1'b1, 'h400 + 4 * j);
            tick();
        end
        set_alloc(1'b0, 0, 1'b0, 0);
        set_haz(1'b1, 13, 1'b0, 0, 1'b1, 14);
        #1;
        check("mid_pre_rs1", oitfrd_match_disprs1, 1);
        check("mid_pre_ptr", disp_oitf_ptr, 2);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_empty",  oitf_empty, 1);
        check("mid_rst_ready",  disp_oitf_ready, 1);
        check("mid_rst_rs1",    oitfrd_match_disprs1, 0);
        check("mid_rst_rd",     oitfrd_match_disprd, 0);
        check("mid_rst_ptr",    disp_oitf_ptr, 0);
        check("mid_rst_retptr", oitf_ret_ptr, 0);
        @(negedge clk);
        rst = 1'b0;
        set_haz(1'b0, 0, 1'b0, 0, 1'b0, 0);
        set_alloc(1'b1, 20, 1'b1, 'h500);
        tick();
        set_alloc(1'b0, 0, 1'b0, 0);
        check("post_rst_ptr",    disp_oitf_ptr, 1);
        check("post_rst_retptr", oitf_ret_ptr, 0);
        check("post_rst_retrd",  oitf_ret_rdidx, 20);
        check("post_rst_empty",  oitf_empty, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
